wb_sequencer: RTL and testbench

- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback source and drives the integer register-file write port and the single FP register-file write port.
- Splits double-word (DW) float writes into two single-word beats on consecutive FP registers, stalling upstream for one cycle.
- Exports forwarding data for the hazard/forwarding unit.

---
 rtl/wb_sequencer_pkg.sv | 22 ++
 rtl/wb_src_mux.sv | 47 ++++
 rtl/wb_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_wb_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/wb_sequencer_pkg.sv
// Shared definitions for the writeback sequencer: source encodings, FSM
// states and the default data/register widths.
package wb_sequencer_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Writeback source select encodings
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_src_e;

  // Sequencer state: BEAT2 is the second (high-word) beat of a DW float write
  typedef enum logic {
    IDLE  = 1'b0,
    BEAT2 = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_src_mux.sv
// Writeback source multiplexer.
// Ports:
//   sel              writeback source (ALU / Mem / PC+4 / Imm)
//   alu1, alu2       ALU result low/high word
//   mem1, mem2       memory data low/high word
//   pcp4, imm        PC+4 and immediate
//   lo_data          single-word (or DW low-word) writeback data
//   hi_data          DW high-word data; only ALU and Mem carry a high word
module wb_src_mux
  import wb_sequencer_pkg::*;
#(
  parameter int DATA_W = wb_sequencer_pkg::DATA_W
) (
  input  wb_src_e           sel,
  input  logic [DATA_W-1:0] alu1,
  input  logic [DATA_W-1:0] alu2,
  input  logic [DATA_W-1:0] mem1,
  input  logic [DATA_W-1:0] mem2,
  input  logic [DATA_W-1:0] pcp4,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] lo_data,
  output logic [DATA_W-1:0] hi_data
);

  // Low/single word select
  always_comb begin
    lo_data = {DATA_W{1'b0}};
    case (sel)
      WB_ALU:  lo_data = alu1;
      WB_MEM:  lo_data = mem1;
      WB_PC4:  lo_data = pcp4;
      WB_IMM:  lo_data = imm;
      default: lo_data = {DATA_W{1'b0}};
    endcase
  end

  // High word select; PC+4 and Imm have no high word, so they yield zero
  always_comb begin
    hi_data = {DATA_W{1'b0}};
    case (sel)
      WB_ALU:  hi_data = alu2;
      WB_MEM:  hi_data = mem2;
      default: hi_data = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/wb_sequencer.sv
// Writeback-stage sequencer. Drives the integer and FP register-file write
// ports from the MEM/WB register, splits double-word float writes into two
// beats on consecutive FP registers, and exports a forwarding view.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   iWrite/iFloat/iWBsrc/iDW         MEM/WB control (iWrite is the valid bit)
//   iALUout1/2, iMemOut1/2, iPcp4, iIm  candidate writeback data
//   iDstReg                          destination register
//   oIntWe/oIntAddr/oIntData         integer RF write port
//   oFpWe/oFpAddr/oFpData            FP RF write port
//   oStall                           freeze upstream for the DW second beat
//   oFwdValid/oFwdFloat/oFwdReg/oFwdData  forwarding view of this cycle's write
//   oErr                             sticky protocol-error flag
module wb_sequencer
  import wb_sequencer_pkg::*;
#(
  parameter int DATA_W = wb_sequencer_pkg::DATA_W,
  parameter int REG_W  = wb_sequencer_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iWrite,
  input  logic              iFloat,
  input  logic [1:0]        iWBsrc,
  input  logic              iDW,
  input  logic [DATA_W-1:0] iALUout1,
  input  logic [DATA_W-1:0] iALUout2,
  input  logic [DATA_W-1:0] iMemOut1,
  input  logic [DATA_W-1:0] iMemOut2,
  input  logic [DATA_W-1:0] iPcp4,
  input  logic [DATA_W-1:0] iIm,
  input  logic [REG_W-1:0]  iDstReg,
  output logic              oIntWe,
  output logic [REG_W-1:0]  oIntAddr,
  output logic [DATA_W-1:0] oIntData,
  output logic              oFpWe,
  output logic [REG_W-1:0]  oFpAddr,
  output logic [DATA_W-1:0] oFpData,
  output logic              oStall,
  output logic              oFwdValid,
  output logic              oFwdFloat,
  output logic [REG_W-1:0]  oFwdReg,
  output logic [DATA_W-1:0] oFwdData,
  output logic              oErr
);

  wb_state_e         state_r, state_nx_s;
  logic [DATA_W-1:0] hold_data_r, hold_data_nx_s;
  logic [REG_W-1:0]  hold_addr_r, hold_addr_nx_s;
  logic              err_r, err_nx_s;
  logic [DATA_W-1:0] lo_data_s, hi_data_s;
  logic              fp_req_s, int_req_s, dw_req_s, dw_split_s;
  logic [REG_W-1:0]  dw_lo_addr_s, dw_hi_addr_s;

  wb_src_mux #(.DATA_W(DATA_W)) u_src_mux (
    .sel     (wb_src_e'(iWBsrc)),
    .alu1    (iALUout1),
    .alu2    (iALUout2),
    .mem1    (iMemOut1),
    .mem2    (iMemOut2),
    .pcp4    (iPcp4),
    .imm     (iIm),
    .lo_data (lo_data_s),
    .hi_data (hi_data_s)
  );

  assign fp_req_s     = iWrite & iFloat;
  // Integer writes to register 0 are suppressed entirely (not even forwarded)
  assign int_req_s    = iWrite & ~iFloat & (iDstReg != {REG_W{1'b0}});
  assign dw_req_s     = fp_req_s & iDW;
  // Only ALU and Mem carry a high word; PC+4/Imm DW requests degrade to one beat
  assign dw_split_s   = dw_req_s & ((iWBsrc == WB_ALU) | (iWBsrc == WB_MEM));
  assign dw_lo_addr_s = {iDstReg[REG_W-1:1], 1'b0};
  assign dw_hi_addr_s = {iDstReg[REG_W-1:1], 1'b1};
  assign oErr         = err_r;

  // State, high-word hold and sticky error registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      hold_data_r <= {DATA_W{1'b0}};
      hold_addr_r <= {REG_W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      hold_data_r <= hold_data_nx_s;
      hold_addr_r <= hold_addr_nx_s;
      err_r       <= err_nx_s;
    end
  end

  // Next-state, hold capture and error detection
  always_comb begin
    state_nx_s     = state_r;
    hold_data_nx_s = hold_data_r;
    hold_addr_nx_s = hold_addr_r;
    err_nx_s       = err_r;
    case (state_r)
      IDLE: begin
        if (dw_split_s) begin
          state_nx_s     = BEAT2;
          hold_data_nx_s = hi_data_s;
          hold_addr_nx_s = dw_hi_addr_s;
          // Misaligned DW destination is flagged but still aligned down
          if (iDstReg[0]) begin
            err_nx_s = 1'b1;
          end else begin
            err_nx_s = err_r;
          end
        end else if (dw_req_s) begin
          err_nx_s = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BEAT2: begin
        state_nx_s = IDLE;
        // The FP port is busy with the high word: a float write now is lost
        if (fp_req_s) begin
          err_nx_s = 1'b1;
        end else begin
          err_nx_s = err_r;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Write ports, stall and forwarding view (combinational from inputs/state)
  always_comb begin
    oIntWe    = 1'b0;
    oIntAddr  = {REG_W{1'b0}};
    oIntData  = {DATA_W{1'b0}};
    oFpWe     = 1'b0;
    oFpAddr   = {REG_W{1'b0}};
    oFpData   = {DATA_W{1'b0}};
    oStall    = 1'b0;
    oFwdValid = 1'b0;
    oFwdFloat = 1'b0;
    oFwdReg   = {REG_W{1'b0}};
    oFwdData  = {DATA_W{1'b0}};
    if (rst_n) begin
      if (int_req_s) begin
        oIntWe   = 1'b1;
        oIntAddr = iDstReg;
        oIntData = lo_data_s;
      end else begin
        oIntWe = 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (dw_split_s) begin
            oFpWe   = 1'b1;
            oFpAddr = dw_lo_addr_s;
            oFpData = lo_data_s;
            oStall  = 1'b1;
          end else if (fp_req_s) begin
            oFpWe   = 1'b1;
            oFpAddr = iDstReg;
            oFpData = lo_data_s;
          end else begin
            oFpWe = 1'b0;
          end
        end
        BEAT2: begin
          oFpWe   = 1'b1;
          oFpAddr = hold_addr_r;
          oFpData = hold_data_r;
        end
        default: begin
          oFpWe = 1'b0;
        end
      endcase
      // FP port wins the forwarding view when both ports write
      if (oFpWe) begin
        oFwdValid = 1'b1;
        oFwdFloat = 1'b1;
        oFwdReg   = oFpAddr;
        oFwdData  = oFpData;
      end else if (oIntWe) begin
        oFwdValid = 1'b1;
        oFwdFloat = 1'b0;
        oFwdReg   = oIntAddr;
        oFwdData  = oIntData;
      end else begin
        oFwdValid = 1'b0;
      end
    end else begin
      oStall = 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: directed scenarios followed by random
// traffic, all compared against a queue-based model of pending FP beats.
module tb_wb_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iWrite, iFloat, iDW;
  logic [1:0]  iWBsrc;
  logic [31:0] iALUout1, iALUout2, iMemOut1, iMemOut2, iPcp4, iIm;
  logic [4:0]  iDstReg;
  logic        oIntWe, oFpWe, oStall, oFwdValid, oFwdFloat, oErr;
  logic [4:0]  oIntAddr, oFpAddr, oFwdReg;
  logic [31:0] oIntData, oFpData, oFwdData;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } beat_t;

  beat_t pend_q[$];
  bit    m_err = 1'b0;

  always #5 clk = ~clk;

  wb_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .iWrite(iWrite), .iFloat(iFloat), .iWBsrc(iWBsrc), .iDW(iDW),
    .iALUout1(iALUout1), .iALUout2(iALUout2),
    .iMemOut1(iMemOut1), .iMemOut2(iMemOut2),
    .iPcp4(iPcp4), .iIm(iIm), .iDstReg(iDstReg),
    .oIntWe(oIntWe), .oIntAddr(oIntAddr), .oIntData(oIntData),
    .oFpWe(oFpWe), .oFpAddr(oFpAddr), .oFpData(oFpData),
    .oStall(oStall),
    .oFwdValid(oFwdValid), .oFwdFloat(oFwdFloat), .oFwdReg(oFwdReg), .oFwdData(oFwdData),
    .oErr(oErr)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one MEM/WB entry, compare every output against the model, then
  // advance the model to the state it will hold after the next rising edge.
  task automatic cycle(input string tag, input bit rst, input bit wr, input bit fl,
                       input bit dw, input logic [1:0] src, input logic [4:0] dst,
                       input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] m1, input logic [31:0] m2,
                       input logic [31:0] p4, input logic [31:0] im);
    logic        e_iwe, e_fwe, e_st, e_fv, e_ff;
    logic [4:0]  e_ia, e_fa, e_fr;
    logic [31:0] e_id, e_fd, e_fdat, word, hiw;
    bit          push, nerr;
    @(negedge clk);
    rst_n = rst; iWrite = wr; iFloat = fl; iDW = dw; iWBsrc = src; iDstReg = dst;
    iALUout1 = a1; iALUout2 = a2; iMemOut1 = m1; iMemOut2 = m2; iPcp4 = p4; iIm = im;
    #1;
    e_iwe = 1'b0; e_ia = 5'd0; e_id = 32'd0;
    e_fwe = 1'b0; e_fa = 5'd0; e_fd = 32'd0;
    e_st = 1'b0; e_fv = 1'b0; e_ff = 1'b0; e_fr = 5'd0; e_fdat = 32'd0;
    push = 1'b0; nerr = m_err;
    word = (src == 2'd0) ? a1 : (src == 2'd1) ? m1 : (src == 2'd2) ? p4 : im;
    hiw  = (src == 2'd0) ? a2 : m2;
    if (rst) begin
      if (pend_q.size() > 0) begin
        e_fwe = 1'b1; e_fa = pend_q[0].addr; e_fd = pend_q[0].data;
        if (wr && fl) nerr = 1'b1;
      end else if (wr && fl) begin
        if (dw && src < 2'd2) begin
          e_fwe = 1'b1; e_fa = {dst[4:1], 1'b0}; e_fd = word; e_st = 1'b1;
          push = 1'b1;
          if (dst[0]) nerr = 1'b1;
        end else begin
          e_fwe = 1'b1; e_fa = dst; e_fd = word;
          if (dw) nerr = 1'b1;
        end
      end
      if (wr && !fl && dst != 5'd0) begin
        e_iwe = 1'b1; e_ia = dst; e_id = word;
      end
      if (e_fwe) begin
        e_fv = 1'b1; e_ff = 1'b1; e_fr = e_fa; e_fdat = e_fd;
      end else if (e_iwe) begin
        e_fv = 1'b1; e_ff = 1'b0; e_fr = e_ia; e_fdat = e_id;
      end
    end
    check_val({tag, ".int_we"},   oIntWe,    e_iwe);
    check_val({tag, ".int_addr"}, oIntAddr,  e_ia);
    check_val({tag, ".int_data"}, oIntData,  e_id);
    check_val({tag, ".fp_we"},    oFpWe,     e_fwe);
    check_val({tag, ".fp_addr"},  oFpAddr,   e_fa);
    check_val({tag, ".fp_data"},  oFpData,   e_fd);
    check_val({tag, ".stall"},    oStall,    e_st);
    check_val({tag, ".fwd_v"},    oFwdValid, e_fv);
    check_val({tag, ".fwd_f"},    oFwdFloat, e_ff);
    check_val({tag, ".fwd_reg"},  oFwdReg,   e_fr);
    check_val({tag, ".fwd_data"}, oFwdData,  e_fdat);
    check_val({tag, ".err"},      oErr,      m_err);
    if (!rst) begin
      pend_q.delete();
      m_err = 1'b0;
    end else begin
      if (pend_q.size() > 0) begin
        void'(pend_q.pop_front());
      end else if (push) begin
        pend_q.push_back('{addr: {dst[4:1], 1'b1}, data: hiw});
      end
      m_err = nerr;
    end
  endtask

  task automatic bubble(input string tag);
    cycle(tag, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic reset_cycle(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; iWrite = 1'b0; iFloat = 1'b0; iDW = 1'b0; iWBsrc = 2'd0; iDstReg = 5'd0;
    iALUout1 = 32'd0; iALUout2 = 32'd0; iMemOut1 = 32'd0; iMemOut2 = 32'd0;
    iPcp4 = 32'd0; iIm = 32'd0;

    reset_cycle("rst0");
    reset_cycle("rst1");
    bubble("idle");

    // Integer ALU write to r5
    cycle("int_alu", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 5'd5, 32'h1234, 32'h9, 32'h8, 32'h7, 32'h6, 32'h5);
    check_val("int_alu.data_const", oIntData, 32'h0000_1234);
    // Integer write to r0 is suppressed
    cycle("int_r0", 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 5'd0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h77);
    // PC+4 and Imm sources, single FP write
    cycle("int_pc4", 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 5'd9, 32'h1, 32'h2, 32'h3, 32'h4, 32'h400, 32'h5);
    cycle("fp_imm", 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 5'd11, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'hCAFE);

    // DW load to f4/f5
    cycle("dw_ld0", 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 5'd4, 32'h1, 32'h2, 32'hAAAA0000, 32'hBBBB1111, 32'h5, 32'h6);
    check_val("dw_ld0.stall_const", oStall, 32'd1);
    bubble("dw_ld1");
    check_val("dw_ld1.fp_const", oFpData, 32'hBBBB1111);

    // DW to f8, integer write r3=7 overlapping the second beat
    cycle("ovl0", 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 5'd8, 32'h1111, 32'h2222, 32'h3, 32'h4, 32'h5, 32'h6);
    cycle("ovl1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 5'd3, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h7);
    check_val("ovl1.fwd_reg_const", oFwdReg, 32'd9);
    check_val("ovl1.err_clean", oErr, 32'd0);

    // Float write during the second beat is dropped and flags an error
    cycle("fpb2_0", 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 5'd12, 32'h1, 32'h2, 32'h30, 32'h40, 32'h5, 32'h6);
    cycle("fpb2_1", 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 5'd20, 32'hDEAD, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6);
    bubble("fpb2_2");
    check_val("fpb2_2.err_const", oErr, 32'd1);
    reset_cycle("clr0");
    bubble("clr1");

    // Misaligned DW destination f7 -> writes f6/f7, error
    cycle("dw7_0", 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 5'd7, 32'h66, 32'h77, 32'h3, 32'h4, 32'h5, 32'h6);
    bubble("dw7_1");
    bubble("dw7_2");
    reset_cycle("clr2");
    bubble("clr3");

    // DW with Imm source -> single FP write plus error
    cycle("dwimm", 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 5'd14, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'hF00D);
    bubble("dwimm1");

    // Reset during the second beat discards the high word
    cycle("rdw0", 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 5'd16, 32'hA, 32'hB, 32'h3, 32'h4, 32'h5, 32'h6);
    reset_cycle("rdw1");
    bubble("rdw2");
    check_val("rdw2.err_const", oErr, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit         r_rst, r_wr;
      logic [4:0] r_dst;
      r_rst = ($urandom_range(0, 59) != 0);
      r_wr  = (pend_q.size() > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      r_dst = 5'($urandom_range(0, 31));
      cycle($sformatf("rnd%0d", i), r_rst, r_wr, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), r_dst,
            $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
